conv_pool_1d: RTL and testbench
===============================

Name: conv_pool_1d

Overview:
Streaming 1-D pooling stage directly downstream of conv_1d. It consumes the convolution result stream (data/vld/last/rdy), reduces each non-overlapping window of POOL_SIZE results to one value (max or sum), and emits the pooled stream with the same valid/ready/last handshake. A `last` beat closes a partial window early, so frame boundaries are preserved.

Parameters:
IN_WIDTH, 18, width of the incoming conv result (8-bit data, kernel 4: 16 + clog2(4)); unsigned.
POOL_SIZE, 2, window length and stride; must be >= 1.
MODE, 0, 0 = max pooling, 1 = sum pooling.
OUT_WIDTH, IN_WIDTH + $clog2(POOL_SIZE), derived; do not override.

Ports:
clk  input  1  clock; all logic on the rising edge.
arst  input  1  asynchronous active-high reset.
in_data  input  IN_WIDTH  conv result sample, unsigned.
in_vld  input  1  in_data valid.
in_last  input  1  final sample of the frame; qualified by in_vld.
in_rdy  output  1  block accepts a beat this cycle.
out_data  output  OUT_WIDTH  pooled value; max results are zero-extended.
out_vld  output  1  out_data valid.
out_last  output  1  pooled value closes the frame.
out_rdy  input  1  downstream accepts out_data.

Behaviour:
- Reset (async assert, sync-style deassert honoured at next edge): cnt=0, acc=0, out_vld=0, out_data=0, out_last=0. in_rdy is 1 once out_vld=0.
- Input accept = in_vld & in_rdy. Output accept = out_vld & out_rdy.
- in_rdy = !out_vld | out_rdy (combinational from out_rdy; single output register, full throughput, no skid).
- Window state: counter cnt in 0..POOL_SIZE-1, and accumulator acc of OUT_WIDTH bits.
- On input accept:
  - val = (cnt==0) ? in_data : op(acc, in_data). op is max(a,b) for MODE=0 and a+b for MODE=1. Sum never overflows in OUT_WIDTH.
  - If cnt==POOL_SIZE-1 or in_last: out_data<=val, out_last<=in_last, out_vld<=1, cnt<=0.
  - Otherwise acc<=val and cnt<=cnt+1.
- Latency: the pooled value is visible on out_vld one cycle after the beat that completes its window.
- Partial window on in_last: the block emits the reduction of the samples received so far. A sum is not normalised. A lone sample passes through unchanged.
- Output accept with no new completion that cycle: out_vld<=0. out_data and out_last hold their old values (don't-care).
- Output accept and a completing input accept in the same cycle: the output register reloads, out_vld stays 1, and there is no bubble.
- While out_vld=1 and out_rdy=0: in_rdy=0, and acc, cnt and the output register all hold stably.
- in_vld=0 gaps leave acc and cnt untouched. A window may span any number of idle cycles.
- POOL_SIZE=1: pure registered pass-through. out_last=in_last.
- Reset mid-window or mid-stall discards the partial window and any pending output. There is no spurious out_vld after reset.
- in_data and in_last are ignored when in_vld=0.

Test Plan:
- MODE=0, POOL_SIZE=2, out_rdy=1, input 10,30,20,5 back-to-back (last on 5) -> out 30 then 20 (out_last=1), each 1 cycle after its 2nd sample, in_rdy stays 1.
- MODE=1, POOL_SIZE=2, same stimulus -> out 40 then 25 (last=1). Input 2^18-1 twice -> out 2^19-2, no wrap.
- MODE=0, POOL_SIZE=2, input 7,3,9(last) -> out 7 (last=0) then 9 (last=1); the next frame starts with cnt=0.
- in_vld gaps: samples 4,_,_,8 with in_vld=0 in the gaps, MODE=1 -> single out 12. acc is unchanged during the gaps.
- Backpressure: hold out_rdy=0 after the first window completes -> out_vld=1 and out_data stable, in_rdy=0, and the upstream beat is held. Release out_rdy alongside a completing beat -> back-to-back outputs with no lost or duplicated value.
- Assert arst after 1 of 2 samples, and again while out_vld=1 is stalled -> out_vld=0 immediately. After deassert, 1,2 -> out 2 (MODE=0) with no stale data.

Source files
------------

// File: rtl/conv_pool_1d.sv
// Streaming 1-D pooling stage behind conv_1d: reduces non-overlapping
// windows of POOL_SIZE samples (max or sum); a last beat closes a window early.
module conv_pool_1d #(
    parameter int IN_WIDTH  = 18,
    parameter int POOL_SIZE = 2,
    parameter int MODE      = 0,
    parameter int OUT_WIDTH = IN_WIDTH + $clog2(POOL_SIZE)
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_vld,
    input  logic                 in_last,
    output logic                 in_rdy,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_vld,
    output logic                 out_last,
    input  logic                 out_rdy
);

    localparam int CW = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(POOL_SIZE - 1);

    logic [CW-1:0]        cnt;
    logic [OUT_WIDTH-1:0] acc;
    logic [OUT_WIDTH-1:0] ext;
    logic [OUT_WIDTH-1:0] val;
    logic                 in_acc;
    logic                 out_acc;
    logic                 close;

    // Single output register: a new beat is taken whenever the slot drains.
    assign in_rdy  = !out_vld || out_rdy;
    assign in_acc  = in_vld && in_rdy;
    assign out_acc = out_vld && out_rdy;
    assign ext     = OUT_WIDTH'(in_data);
    assign close   = (cnt == CNT_MAX) || in_last;

    always_comb begin
        val = ext;
        if (cnt != '0) begin
            if (MODE == 0) begin
                val = (acc > ext) ? acc : ext;
            end else begin
                val = acc + ext;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt      <= '0;
            acc      <= '0;
            out_data <= '0;
            out_vld  <= 1'b0;
            out_last <= 1'b0;
        end else begin
            if (out_acc) begin
                out_vld <= 1'b0;
            end
            if (in_acc) begin
                if (close) begin
                    out_data <= val;
                    out_last <= in_last;
                    out_vld  <= 1'b1;
                    cnt      <= '0;
                end else begin
                    acc <= val;
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_pool_1d.sv
// Directed bench for conv_pool_1d: max, sum and pass-through instances
// share one input stream and one out_rdy.
module tb_conv_pool_1d;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [17:0] in_data = '0;
    logic        in_vld = 1'b0;
    logic        in_last = 1'b0;
    logic        out_rdy = 1'b1;

    logic        mx_rdy, mx_vld, mx_last;
    logic [18:0] mx_data;
    logic        sm_rdy, sm_vld, sm_last;
    logic [18:0] sm_data;
    logic        ps_rdy, ps_vld, ps_last;
    logic [17:0] ps_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_pool_1d #(.IN_WIDTH(18), .POOL_SIZE(2), .MODE(0)) u_max (
        .clk(clk), .arst(arst), .in_data(in_data), .in_vld(in_vld),
        .in_last(in_last), .in_rdy(mx_rdy), .out_data(mx_data),
        .out_vld(mx_vld), .out_last(mx_last), .out_rdy(out_rdy)
    );

    conv_pool_1d #(.IN_WIDTH(18), .POOL_SIZE(2), .MODE(1)) u_sum (
        .clk(clk), .arst(arst), .in_data(in_data), .in_vld(in_vld),
        .in_last(in_last), .in_rdy(sm_rdy), .out_data(sm_data),
        .out_vld(sm_vld), .out_last(sm_last), .out_rdy(out_rdy)
    );

    conv_pool_1d #(.IN_WIDTH(18), .POOL_SIZE(1), .MODE(0)) u_pass (
        .clk(clk), .arst(arst), .in_data(in_data), .in_vld(in_vld),
        .in_last(in_last), .in_rdy(ps_rdy), .out_data(ps_data),
        .out_vld(ps_vld), .out_last(ps_last), .out_rdy(out_rdy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [17:0] d, input logic l);
        in_vld  = 1'b1;
        in_data = d;
        in_last = l;
        step();
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic do_reset();
        in_vld  = 1'b0;
        in_last = 1'b0;
        out_rdy = 1'b1;
        arst    = 1'b1;
        step();
        arst = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        in_vld = 1'b0;
        step();
        checks++; if (mx_vld !== 1'b0) begin errors++; $display("FAIL rst_vld got %0b want 0", mx_vld); end
        checks++; if (mx_data !== 19'd0) begin errors++; $display("FAIL rst_data got %0d want 0", mx_data); end
        checks++; if (mx_last !== 1'b0) begin errors++; $display("FAIL rst_last got %0b want 0", mx_last); end
        checks++; if (mx_rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy got %0b want 1", mx_rdy); end
        checks++; if (sm_vld !== 1'b0) begin errors++; $display("FAIL rst_sum_vld got %0b want 0", sm_vld); end
        arst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        send(18'd10, 1'b0);
        checks++; if (mx_vld !== 1'b0) begin errors++; $display("FAIL basic_v0 got %0b want 0", mx_vld); end
        checks++; if (mx_rdy !== 1'b1) begin errors++; $display("FAIL basic_rdy0 got %0b want 1", mx_rdy); end
        send(18'd30, 1'b0);
        checks++; if (mx_vld !== 1'b1 || mx_data !== 19'd30 || mx_last !== 1'b0) begin errors++; $display("FAIL basic_max1 got v%0b d%0d l%0b want v1 d30 l0", mx_vld, mx_data, mx_last); end
        checks++; if (sm_vld !== 1'b1 || sm_data !== 19'd40) begin errors++; $display("FAIL basic_sum1 got v%0b d%0d want v1 d40", sm_vld, sm_data); end
        checks++; if (mx_rdy !== 1'b1) begin errors++; $display("FAIL basic_rdy1 got %0b want 1", mx_rdy); end
        send(18'd20, 1'b0);
        checks++; if (mx_vld !== 1'b0) begin errors++; $display("FAIL basic_drain got %0b want 0", mx_vld); end
        send(18'd5, 1'b1);
        checks++; if (mx_vld !== 1'b1 || mx_data !== 19'd20 || mx_last !== 1'b1) begin errors++; $display("FAIL basic_max2 got v%0b d%0d l%0b want v1 d20 l1", mx_vld, mx_data, mx_last); end
        checks++; if (sm_vld !== 1'b1 || sm_data !== 19'd25 || sm_last !== 1'b1) begin errors++; $display("FAIL basic_sum2 got v%0b d%0d l%0b want v1 d25 l1", sm_vld, sm_data, sm_last); end
        step();
        checks++; if (mx_vld !== 1'b0) begin errors++; $display("FAIL basic_idle got %0b want 0", mx_vld); end
    endtask

    task automatic test_no_wrap();
        do_reset();
        send(18'h3ffff, 1'b0);
        send(18'h3ffff, 1'b0);
        checks++; if (sm_data !== 19'd524286) begin errors++; $display("FAIL sum_wrap got %0d want 524286", sm_data); end
        checks++; if (mx_data !== 19'd262143) begin errors++; $display("FAIL max_full got %0d want 262143", mx_data); end
    endtask

    task automatic test_partial();
        do_reset();
        send(18'd7, 1'b0);
        send(18'd3, 1'b0);
        checks++; if (mx_data !== 19'd7 || mx_last !== 1'b0) begin errors++; $display("FAIL part_w1 got d%0d l%0b want d7 l0", mx_data, mx_last); end
        send(18'd9, 1'b1);
        checks++; if (mx_vld !== 1'b1 || mx_data !== 19'd9 || mx_last !== 1'b1) begin errors++; $display("FAIL part_lone got v%0b d%0d l%0b want v1 d9 l1", mx_vld, mx_data, mx_last); end
        checks++; if (sm_data !== 19'd9 || sm_last !== 1'b1) begin errors++; $display("FAIL part_sum got d%0d l%0b want d9 l1", sm_data, sm_last); end
        send(18'd1, 1'b0);
        checks++; if (mx_vld !== 1'b0) begin errors++; $display("FAIL part_cnt0 got %0b want 0", mx_vld); end
        send(18'd6, 1'b0);
        checks++; if (mx_data !== 19'd6 || mx_last !== 1'b0) begin errors++; $display("FAIL part_next got d%0d l%0b want d6 l0", mx_data, mx_last); end
        checks++; if (sm_data !== 19'd7) begin errors++; $display("FAIL part_nsum got %0d want 7", sm_data); end
    endtask

    task automatic test_gaps();
        do_reset();
        send(18'd4, 1'b0);
        step();
        step();
        checks++; if (sm_vld !== 1'b0) begin errors++; $display("FAIL gap_idle got %0b want 0", sm_vld); end
        send(18'd8, 1'b0);
        checks++; if (sm_vld !== 1'b1 || sm_data !== 19'd12) begin errors++; $display("FAIL gap_sum got v%0b d%0d want v1 d12", sm_vld, sm_data); end
        checks++; if (mx_data !== 19'd8) begin errors++; $display("FAIL gap_max got %0d want 8", mx_data); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send(18'd5, 1'b0);
        checks++; if (ps_vld !== 1'b1 || ps_data !== 18'd5) begin errors++; $display("FAIL pass_0 got v%0b d%0d want v1 d5", ps_vld, ps_data); end
        send(18'd6, 1'b1);
        checks++; if (ps_vld !== 1'b1 || ps_data !== 18'd6 || ps_last !== 1'b1) begin errors++; $display("FAIL pass_1 got v%0b d%0d l%0b want v1 d6 l1", ps_vld, ps_data, ps_last); end
        send(18'd7, 1'b0);
        checks++; if (ps_data !== 18'd7 || ps_last !== 1'b0) begin errors++; $display("FAIL pass_2 got d%0d l%0b want d7 l0", ps_data, ps_last); end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_vld = 1'b1;
        in_data = 18'd10;
        step();
        checks++; if (ps_vld !== 1'b1 || ps_data !== 18'd10) begin errors++; $display("FAIL bp_pass0 got v%0b d%0d want v1 d10", ps_vld, ps_data); end
        out_rdy = 1'b0;
        in_data = 18'd50;
        #1;
        checks++; if (mx_rdy !== 1'b1 || ps_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy_comb got %0b%0b want 10", mx_rdy, ps_rdy); end
        step();
        checks++; if (mx_vld !== 1'b1 || mx_data !== 19'd50 || mx_rdy !== 1'b0) begin errors++; $display("FAIL bp_stall got v%0b d%0d r%0b want v1 d50 r0", mx_vld, mx_data, mx_rdy); end
        in_data = 18'd7;
        step();
        step();
        checks++; if (mx_vld !== 1'b1 || mx_data !== 19'd50 || mx_rdy !== 1'b0) begin errors++; $display("FAIL bp_hold got v%0b d%0d r%0b want v1 d50 r0", mx_vld, mx_data, mx_rdy); end
        checks++; if (ps_vld !== 1'b1 || ps_data !== 18'd10) begin errors++; $display("FAIL bp_pass_hold got v%0b d%0d want v1 d10", ps_vld, ps_data); end
        out_rdy = 1'b1;
        #1;
        checks++; if (mx_rdy !== 1'b1 || ps_rdy !== 1'b1) begin errors++; $display("FAIL bp_release got %0b%0b want 11", mx_rdy, ps_rdy); end
        step();
        checks++; if (ps_vld !== 1'b1 || ps_data !== 18'd7) begin errors++; $display("FAIL bp_pass_b2b got v%0b d%0d want v1 d7", ps_vld, ps_data); end
        checks++; if (mx_vld !== 1'b0) begin errors++; $display("FAIL bp_max_drain got %0b want 0", mx_vld); end
        in_data = 18'd9;
        in_last = 1'b1;
        step();
        in_vld = 1'b0;
        in_last = 1'b0;
        checks++; if (mx_vld !== 1'b1 || mx_data !== 19'd9 || mx_last !== 1'b1) begin errors++; $display("FAIL bp_max_win got v%0b d%0d l%0b want v1 d9 l1", mx_vld, mx_data, mx_last); end
        checks++; if (ps_vld !== 1'b1 || ps_data !== 18'd9 || ps_last !== 1'b1) begin errors++; $display("FAIL bp_pass_last got v%0b d%0d l%0b want v1 d9 l1", ps_vld, ps_data, ps_last); end
        step();
        checks++; if (mx_vld !== 1'b0 || ps_vld !== 1'b0) begin errors++; $display("FAIL bp_end got %0b%0b want 00", mx_vld, ps_vld); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send(18'd1, 1'b0);
        arst = 1'b1;
        #1;
        checks++; if (mx_vld !== 1'b0) begin errors++; $display("FAIL mr_win got %0b want 0", mx_vld); end
        step();
        arst = 1'b0;
        out_rdy = 1'b0;
        send(18'd3, 1'b0);
        send(18'd4, 1'b0);
        checks++; if (mx_vld !== 1'b1 || mx_data !== 19'd4) begin errors++; $display("FAIL mr_stall got v%0b d%0d want v1 d4", mx_vld, mx_data); end
        #2;
        arst = 1'b1;
        #1;
        checks++; if (mx_vld !== 1'b0 || mx_data !== 19'd0) begin errors++; $display("FAIL mr_async got v%0b d%0d want v0 d0", mx_vld, mx_data); end
        step();
        arst = 1'b0;
        out_rdy = 1'b1;
        send(18'd1, 1'b0);
        checks++; if (mx_vld !== 1'b0) begin errors++; $display("FAIL mr_spurious got %0b want 0", mx_vld); end
        send(18'd2, 1'b0);
        checks++; if (mx_vld !== 1'b1 || mx_data !== 19'd2 || mx_last !== 1'b0) begin errors++; $display("FAIL mr_fresh got v%0b d%0d l%0b want v1 d2 l0", mx_vld, mx_data, mx_last); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_wrap();
        test_partial();
        test_gaps();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
